ysyx_22050612_ifu_ctrl: RTL and testbench

Fetch sequencer for the NPC front end. Owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures the 32-bit response. It hands the captured instruction to the decode stage over a valid/ready handshake and applies branch/jump redirects from the execute stage, discarding any fetch already in flight. It sits between the PC register datapath and the IDU.

---
 rtl/ysyx_22050612_pkg.sv | 34 +++
 rtl/ysyx_22050612_ifu_ctrl_if.sv | 37 +++
 rtl/ysyx_22050612_pc_reg.sv | 47 ++++
 rtl/ysyx_22050612_ifu_ctrl.sv | 157 +++++++++++++++
 tb/tb_ysyx_22050612_ifu_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050612_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_pkg
// Shared definitions for the NPC fetch front end: datapath widths, the
// default reset PC, the fetch-sequencer state encoding and the next-PC
// select encoding used between the sequencer and its PC register.
// ---------------------------------------------------------------------------
package ysyx_22050612_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ifu_state_e;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

    // Instructions are 4-byte aligned; low address bits of a redirect are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifu_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_ifu_ctrl_if
// Bundles the fetch sequencer's bus-side signals:
//   imem request  : imem_req_valid/imem_req_ready/imem_req_addr
//   imem response : imem_rsp_valid/imem_rsp_data
//   redirect      : redirect_valid/redirect_pc (from execute)
//   decode        : inst_valid/inst_ready/inst/inst_pc (to IDU)
// master = the fetch sequencer, slave = the memory/execute/decode side.
// ---------------------------------------------------------------------------
interface ysyx_22050612_ifu_ctrl_if;
    import ysyx_22050612_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ysyx_22050612_pc_reg.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_pc_reg
// Architectural fetch PC register with its next-PC mux.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (PC -> P_RESET_PC)
//   i_sel           next-PC source: hold, +4 (wraps mod 2^64), redirect
//   i_redirect_pc   redirect target, low two bits forced to zero
//   o_pc            current PC
// ---------------------------------------------------------------------------
module ysyx_22050612_pc_reg
    import ysyx_22050612_pkg::*;
#(
    parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         i_sel,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Next-PC selection
    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_REDIR: w_pc_next = align_pc(i_redirect_pc);
            PC_INC:   w_pc_next = r_pc + 64'd4;
            PC_HOLD:  w_pc_next = r_pc;
            default:  w_pc_next = r_pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= P_RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22050612_ifu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_ifu_ctrl
// Fetch sequencer for the NPC front end. Issues one imem request at a time,
// captures the 32-bit response, holds it for decode and applies redirects,
// discarding any fetch already in flight.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus (master)      imem request/response, redirect, decode handshake
//   pc                current fetch PC (equals bus.imem_req_addr)
//   perf_fetch_cnt    decode accepts        (only with YSYX_22050612_IFU_PERF_EN)
//   perf_kill_cnt     discarded fetches     (only with YSYX_22050612_IFU_PERF_EN)
// Optional feature macro: YSYX_22050612_IFU_PERF_EN enables the two
// 64-bit wrapping performance counters and their ports.
// ---------------------------------------------------------------------------
module ysyx_22050612_ifu_ctrl
    import ysyx_22050612_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050612_ifu_ctrl_if.master bus,
    output logic [XLEN-1:0]          pc
`ifdef YSYX_22050612_IFU_PERF_EN
    ,
    output logic [63:0]              perf_fetch_cnt,
    output logic [63:0]              perf_kill_cnt
`endif
);

    ifu_state_e        r_state;
    logic              r_kill;
    logic [INST_W-1:0] r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic [XLEN-1:0]   w_pc;
    pc_sel_e           w_pc_sel;
    logic              w_req_fire;
    logic              w_rsp;

    assign w_req_fire = (r_state == FETCH) && bus.imem_req_ready;
    // Responses outside WAIT are protocol errors and are ignored here.
    assign w_rsp      = (r_state == WAIT) && bus.imem_rsp_valid;

    // Redirect outranks the +4 advance in every state
    always_comb begin
        w_pc_sel = PC_HOLD;
        if (bus.redirect_valid) begin
            w_pc_sel = PC_REDIR;
        end else if ((r_state == HOLD) && bus.inst_ready) begin
            w_pc_sel = PC_INC;
        end else begin
            w_pc_sel = PC_HOLD;
        end
    end

    ysyx_22050612_pc_reg #(
        .P_RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (bus.redirect_pc),
        .o_pc          (w_pc)
    );

    // Fetch FSM, kill flag and instruction latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_kill    <= 1'b0;
            r_inst    <= {INST_W{1'b0}};
            r_inst_pc <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (w_req_fire) begin
                        // A redirect in the handshake cycle makes the accepted request stale.
                        r_state <= WAIT;
                        r_kill  <= bus.redirect_valid;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        if (w_rsp) begin
                            r_state <= FETCH;
                            r_kill  <= 1'b0;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (w_rsp) begin
                        if (r_kill) begin
                            r_state <= FETCH;
                            r_kill  <= 1'b0;
                        end else begin
                            r_state   <= HOLD;
                            r_inst    <= bus.imem_rsp_data;
                            r_inst_pc <= w_pc;
                        end
                    end else begin
                        r_state <= WAIT;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        r_state <= FETCH;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = (r_state == FETCH);
    assign bus.imem_req_addr  = w_pc;
    assign bus.inst_valid     = (r_state == HOLD);
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign pc                 = w_pc;

`ifdef YSYX_22050612_IFU_PERF_EN
    logic        w_accept;
    logic        w_discard;
    logic [63:0] r_perf_fetch;
    logic [63:0] r_perf_kill;

    assign w_accept  = (r_state == HOLD) && bus.inst_ready && !bus.redirect_valid;
    assign w_discard = (w_rsp && (r_kill || bus.redirect_valid)) ||
                       ((r_state == HOLD) && bus.redirect_valid);

    // Performance counters, wrapping at 2^64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= 64'd0;
            r_perf_kill  <= 64'd0;
        end else begin
            if (w_accept) begin
                r_perf_fetch <= r_perf_fetch + 64'd1;
            end
            if (w_discard) begin
                r_perf_kill <= r_perf_kill + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_kill_cnt  = r_perf_kill;
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050612_ifu_ctrl
// Self-checking bench for the fetch sequencer. A memory model answers
// requests after a programmable latency; expected {inst, inst_pc} entries
// are pushed when a non-stale response is driven and compared while the
// instruction is held and popped when decode accepts it.
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_ifu_ctrl;
    import ysyx_22050612_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
`ifdef YSYX_22050612_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_kill_cnt;
`endif

    ysyx_22050612_ifu_ctrl_if bus();

    ysyx_22050612_ifu_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .pc             (pc)
`ifdef YSYX_22050612_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk;
    int          n_err;
    // stimulus knobs
    int          k_lat;
    logic        k_ready;
    logic        k_dready;
    // memory model
    logic        m_pend;
    int          m_cnt;
    logic [63:0] m_addr;
    logic        m_stale;
    // bench model of the fetch sequencer's visible behaviour
    logic [63:0] e_pc;
    logic        e_valid;
    logic        e_req;
    logic [63:0] e_fetch;
    logic [63:0] e_kill;
    logic        t_hs;
    logic        t_acc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_pc    = RESET_PC;
        e_valid = 1'b0;
        e_req   = 1'b0;
        e_fetch = 64'd0;
        e_kill  = 64'd0;
        m_pend  = 1'b0;
        m_cnt   = 0;
        m_stale = 1'b0;
        t_hs    = 1'b0;
        t_acc   = 1'b0;
        sb.delete();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic check_perf();
`ifdef YSYX_22050612_IFU_PERF_EN
        check("perf_fetch", perf_fetch_cnt, e_fetch);
        check("perf_kill", perf_kill_cnt, e_kill);
`endif
    endtask

    // One cycle: called at a negedge; checks outputs, drives inputs for the
    // next rising edge, updates the model and returns at the next negedge.
    task automatic tick();
        logic rd;
        logic rsp;
        logic push;
        exp_t f;
        rd   = bus.redirect_valid;
        rsp  = 1'b0;
        push = 1'b0;
        check("pc", pc, e_pc);
        check("inst_valid", bus.inst_valid, e_valid);
        if (e_valid && sb.size() > 0) begin
            f = sb[0];
            check("inst", bus.inst, f.inst);
            check("inst_pc", bus.inst_pc, f.pc);
            check("no_req_in_hold", bus.imem_req_valid, 1'b0);
        end
        if (e_req) check("req_valid", bus.imem_req_valid, 1'b1);
        bus.imem_rsp_valid = 1'b0;
        if (m_pend) begin
            if (m_cnt <= 1) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(m_addr);
                rsp    = 1'b1;
                m_pend = 1'b0;
                push   = !(m_stale || rd);
                if (push) sb.push_back({mem_word(e_pc), e_pc});
            end else begin
                m_cnt--;
                if (rd) m_stale = 1'b1;
            end
        end
        bus.imem_req_ready = k_ready;
        t_hs = bus.imem_req_valid && k_ready;
        if (t_hs) begin
            check("req_addr", bus.imem_req_addr, e_pc);
            m_pend  = 1'b1;
            m_cnt   = k_lat;
            m_addr  = bus.imem_req_addr;
            m_stale = rd;
        end
        bus.inst_ready = k_dready;
        t_acc = e_valid && k_dready && !rd;
        e_req = t_acc || (rsp && !push) || (rd && e_valid);
        if ((rsp && !push) || (rd && e_valid)) e_kill++;
        if (t_acc) begin
            if (sb.size() > 0) sb.delete(0);
            e_pc = e_pc + 64'd4;
            e_fetch++;
        end
        if (rd) begin
            e_pc = {bus.redirect_pc[63:2], 2'b00};
            if (e_valid && sb.size() > 0) sb.delete(0);
        end
        if (push) e_valid = 1'b1;
        else if (t_acc || rd) e_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic redirect(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic run_until_hs(input int max);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (t_hs) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_until_acc(input int max);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (t_acc) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("acc_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_until_valid(input int max);
        for (int i = 0; i < max; i++) begin
            if (e_valid) break;
            tick();
        end
        if (!e_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    // Asynchronous reset pulse away from any clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_pc", pc, RESET_PC);
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_inst", bus.inst, 64'd0);
        check("rst_inst_pc", bus.inst_pc, 64'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b1;
        k_lat    = 1;
        k_ready  = 1'b1;
        k_dready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_pc", pc, 64'h0000_0000_8000_0000);
        check("reset_req_valid", bus.imem_req_valid, 1'b0);
        check("reset_inst_valid", bus.inst_valid, 1'b0);
        check("reset_inst", bus.inst, 64'd0);
        check("reset_inst_pc", bus.inst_pc, 64'd0);
        check_perf();
        rst = 1'b0;

        // First fetch with backpressure held for five cycles
        run_until_hs(5);
        k_dready = 1'b0;
        run_until_valid(5);
        repeat (5) tick();
        k_dready = 1'b1;
        run_until_acc(3);
        check("pc_after_accept", pc, 64'h0000_0000_8000_0004);
        run_until_hs(3);
        run_until_acc(5);

        // Redirect while waiting for a slow response
        k_lat = 3;
        run_until_hs(5);
        redirect(64'h0000_0000_8000_0103);
        run_until_hs(10);
        check("pc_redirect_wait", pc, 64'h0000_0000_8000_0100);
        check_perf();
        k_lat = 1;
        run_until_acc(6);

        // Redirect on the handshake, then redirect on the response
        redirect(64'h0000_0000_8000_0200);
        run_until_hs(5);
        redirect(64'h0000_0000_8000_0304);
        run_until_hs(5);
        run_until_acc(5);
        check_perf();

        // Randomised traffic with occasional redirects
        for (int i = 0; i < 300; i++) begin
            k_ready  = ($urandom_range(0, 3) != 0);
            k_dready = ($urandom_range(0, 2) != 0);
            k_lat    = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0)
                redirect({32'd0, 32'h8000_0000 | ($urandom() & 32'h0000_0FFF)});
            else
                tick();
        end
        check_perf();

        // Reset during HOLD, fetch restarts from the reset PC
        k_ready  = 1'b1;
        k_dready = 1'b0;
        k_lat    = 1;
        run_until_valid(20);
        do_reset();
        k_dready = 1'b1;
        run_until_hs(5);
        run_until_acc(5);

        // 100 back-to-back instructions across the top of the address space
        do_reset();
        redirect(64'hFFFF_FFFF_FFFF_FF38);
        for (int i = 0; i < 100; i++) run_until_acc(6);
        check("pc_wrapped", pc, 64'h0000_0000_0000_00C8);
        check("fetch_model_100", e_fetch, 64'd100);
`ifdef YSYX_22050612_IFU_PERF_EN
        check("perf_fetch_100", perf_fetch_cnt, 64'd100);
`endif
        check_perf();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
